// File: rtl/avg_window.sv
// avg_window: running average over the last 2^LOG_DEPTH samples.
//
// A circular sample buffer plus a running sum keeps the cost per sample at a
// fixed four cycles (IDLE/SUB/ADD/OUT), independent of window depth.
//
// Optional build macro: AVG_WINDOW_ROUND_EN
//   defined   -> avg_out = round-half-up(sum / N), saturated to DATA_WIDTH
//   undefined -> avg_out = truncated sum / N
//
// Ports:
//   clk           system clock, rising edge
//   n_reset       asynchronous active-low reset
//   sample_data   sample value, stable while data_ready is high
//   data_ready    asynchronous new-sample strobe (rising edge = one sample)
//   modwait       high while a sample is being processed
//   avg_out       current window average
//   one_k_samples one-cycle pulse every SAMPLE_COUNT accepted samples
//   err           sticky overrun flag, cleared by the next accepted sample
module avg_window #(
    parameter int DATA_WIDTH   = 16,
    parameter int LOG_DEPTH    = 2,
    parameter int SAMPLE_COUNT = 1000
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  data_ready,
    output logic                  modwait,
    output logic [DATA_WIDTH-1:0] avg_out,
    output logic                  one_k_samples,
    output logic                  err
);

    localparam int N  = 1 << LOG_DEPTH;
    localparam int SW = DATA_WIDTH + LOG_DEPTH;
    localparam int CW = $clog2(SAMPLE_COUNT);

    typedef enum logic [1:0] {IDLE, SUB, ADD, OUT} state_t;

    state_t                       state, state_nxt;
    logic                         dr_s1, dr_s2, dr_q;
    logic                         new_dr;
    logic [N-1:0][DATA_WIDTH-1:0] sbuf;
    logic [LOG_DEPTH-1:0]         wptr;
    logic [SW-1:0]                sum;
    logic [DATA_WIDTH-1:0]        sample_reg;
    logic [DATA_WIDTH-1:0]        avg_nxt;
    logic [CW-1:0]                cnt;
    logic                         cnt_last;

    assign new_dr   = dr_s2 & ~dr_q;
    assign cnt_last = (cnt == CW'(SAMPLE_COUNT - 1));

`ifdef AVG_WINDOW_ROUND_EN
    // One extra bit so the rounding constant can never wrap the sum.
    localparam logic [SW:0] RND = (SW+1)'(1) << (LOG_DEPTH - 1);
    localparam logic [SW:0] MAX = (SW+1)'({DATA_WIDTH{1'b1}});
    logic [SW:0] q_full;
    always_comb begin
        q_full  = ({1'b0, sum} + RND) >> LOG_DEPTH;
        avg_nxt = (q_full > MAX) ? {DATA_WIDTH{1'b1}} : q_full[DATA_WIDTH-1:0];
    end
`else
    always_comb begin
        avg_nxt = sum[SW-1:LOG_DEPTH];
    end
`endif

    // 2-flop synchroniser followed by a rising-edge detector.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            dr_s1 <= 1'b0;
            dr_s2 <= 1'b0;
            dr_q  <= 1'b0;
        end else begin
            dr_s1 <= data_ready;
            dr_s2 <= dr_s1;
            dr_q  <= dr_s2;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (new_dr) state_nxt = SUB;
            SUB:  state_nxt = ADD;
            ADD:  state_nxt = OUT;
            OUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sbuf          <= '0;
            wptr          <= '0;
            sum           <= '0;
            sample_reg    <= '0;
            avg_out       <= '0;
            modwait       <= 1'b0;
            cnt           <= '0;
            one_k_samples <= 1'b0;
            err           <= 1'b0;
        end else begin
            one_k_samples <= (state == OUT) && cnt_last;
            // Any strobe outside IDLE (including on the OUT->IDLE edge) is lost.
            if (new_dr) err <= (state != IDLE);
            case (state)
                IDLE: if (new_dr) begin
                    sample_reg <= sample_data;
                    modwait    <= 1'b1;
                end
                // Retire the oldest sample before its slot is overwritten.
                SUB: sum <= sum - SW'(sbuf[wptr]);
                ADD: begin
                    sum        <= sum + SW'(sample_reg);
                    sbuf[wptr] <= sample_reg;
                    wptr       <= wptr + 1'b1;
                end
                OUT: begin
                    avg_out <= avg_nxt;
                    modwait <= 1'b0;
                    cnt     <= cnt_last ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_avg_window.sv
module tb_avg_window;

    localparam int DW = 16;
    localparam int LD = 2;
    localparam int SC = 1000;
    localparam int N  = 1 << LD;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          data_ready = 1'b0;
    logic          modwait;
    logic [DW-1:0] avg_out;
    logic          one_k_samples;
    logic          err;

    int n_chk  = 0;
    int n_fail = 0;
    int n_onek = 0;

    avg_window #(.DATA_WIDTH(DW), .LOG_DEPTH(LD), .SAMPLE_COUNT(SC)) dut (
        .clk(clk), .n_reset(n_reset), .sample_data(sample_data),
        .data_ready(data_ready), .modwait(modwait), .avg_out(avg_out),
        .one_k_samples(one_k_samples), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Acceptance is modelled as: a rise of data_ready seen at edge k takes
    // effect at edge k+2; an accepted sample occupies the block for three
    // further edges, and the result appears at the third.
    int     hist[$];
    longint cyc;
    longint m_acc;
    bit     m_busy, d1, d2, dr_p;
    int     m_cnt;
    int     m_avg;
    bit     m_mw, m_err, m_onek;

    function automatic int window_avg();
        longint s = 0;
        longint r;
        for (int i = 0; i < N; i++)
            if (hist.size() > i) s += hist[hist.size()-1-i];
`ifdef AVG_WINDOW_ROUND_EN
        r = (s + N/2) / N;
        if (r > (1 << DW) - 1) r = (1 << DW) - 1;
`else
        r = s / N;
`endif
        return int'(r);
    endfunction

    initial forever begin
        bit act;
        @(posedge clk or negedge n_reset);
        if (!n_reset) begin
            hist.delete();
            cyc = 0; m_acc = 0; m_busy = 0; d1 = 0; d2 = 0; dr_p = 0;
            m_cnt = 0; m_avg = 0; m_mw = 0; m_err = 0; m_onek = 0;
        end else begin
            cyc++;
            act  = d2;
            d2   = d1;
            d1   = data_ready & ~dr_p;
            dr_p = data_ready;
            m_onek = 0;
            if (act) begin
                if (m_busy) m_err = 1;
                else begin
                    m_busy = 1; m_acc = cyc; m_err = 0;
                    hist.push_back(int'(sample_data));
                end
            end
            if (m_busy && cyc == m_acc + 3 && !(act && m_acc == cyc)) begin
                m_busy = 0;
                m_avg  = window_avg();
                m_cnt++;
                if (m_cnt == SC) begin m_cnt = 0; m_onek = 1; end
            end
            m_mw = m_busy;
        end
    end

    // ---------------- compare process ----------------
    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (n_reset) begin
            check("modwait", int'(modwait), int'(m_mw));
            check("avg_out", int'(avg_out), m_avg);
            check("one_k",   int'(one_k_samples), int'(m_onek));
            check("err",     int'(err), int'(m_err));
            if (one_k_samples) n_onek++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        data_ready = 0;
        n_reset = 0;
        #1;
        check("rst_modwait", int'(modwait), 0);
        check("rst_avg",     int'(avg_out), 0);
        check("rst_onek",    int'(one_k_samples), 0);
        check("rst_err",     int'(err), 0);
        tick(2);
        n_reset = 1;
        tick(1);
    endtask

    task automatic send(int v, int hold = 4);
        sample_data = DW'(v);
        data_ready  = 1;
        tick(hold);
        data_ready  = 0;
        tick(4);
    endtask

    // Second rising edge gap cycles after the first (gap 2 -> mid-processing,
    // gap 3 -> lands on the OUT->IDLE edge).
    task automatic send_overrun(int v, int gap);
        sample_data = DW'(v);
        data_ready  = 1;
        tick(1);
        data_ready  = 0;
        tick(gap - 1);
        data_ready  = 1;
        tick(2);
        data_ready  = 0;
        tick(6);
    endtask

    int exp_seq[5] = '{25, 75, 150, 250, 350};
    int mw_cycles;

    initial begin
        tick(1);
        do_reset();

        // Basic ramp; also count modwait-high cycles for one sample.
        for (int i = 0; i < 5; i++) begin
            sample_data = DW'((i + 1) * 100);
            data_ready  = 1;
            mw_cycles   = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (modwait) mw_cycles++;
                @(posedge clk); #1;
                if (c == 3) data_ready = 0;
            end
            check("ramp_avg", int'(avg_out), exp_seq[i]);
            check("ramp_mw_cycles", mw_cycles, 3);
            check("ramp_err", int'(err), 0);
        end

        // Rounding vs truncation, and full-scale saturation boundary.
        do_reset();
        send(2);
`ifdef AVG_WINDOW_ROUND_EN
        check("single_2", int'(avg_out), 1);
`else
        check("single_2", int'(avg_out), 0);
`endif
        do_reset();
        repeat (4) send(65535);
        check("full_scale", int'(avg_out), 65535);

        // Overrun during processing, then recovery.
        do_reset();
        send(8);
        check("pre_ovr", int'(avg_out), 2);
        send_overrun(40, 2);
        check("ovr_avg", int'(avg_out), 12);
        check("ovr_err", int'(err), 1);
        send(60);
        check("rec_avg", int'(avg_out), 27);
        check("rec_err", int'(err), 0);
        // Overrun on the OUT->IDLE edge.
        send_overrun(20, 3);
        check("ovr_out_avg", int'(avg_out), 32);
        check("ovr_out_err", int'(err), 1);
        send(0);
        check("rec2_avg", int'(avg_out), 30);
        check("rec2_err", int'(err), 0);

        // Level held high accepts a single sample.
        do_reset();
        send(80, 50);
        check("held_avg", int'(avg_out), 20);
        send(40);
        check("held_next", int'(avg_out), 30);

        // Reset while in ADD discards everything.
        sample_data = DW'(400);
        data_ready  = 1;
        tick(4);
        n_reset = 0;
        data_ready = 0;
        #1;
        check("midrst_mw",  int'(modwait), 0);
        check("midrst_avg", int'(avg_out), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_onek", int'(one_k_samples), 0);
        tick(2);
        n_reset = 1;
        tick(1);
        send(400);
        check("post_rst_avg", int'(avg_out), 100);

        // Sample-count strobe over 2000 samples.
        do_reset();
        n_onek = 0;
        for (int i = 1; i <= 2000; i++) begin
            send((i * 37) % 4096);
            if (i == 999)  check("onek_999",  n_onek, 0);
            if (i == 1000) check("onek_1000", n_onek, 1);
            if (i == 1999) check("onek_1999", n_onek, 1);
            if (i == 2000) check("onek_2000", n_onek, 2);
        end

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
